// File: rtl/cntr_load_mode_if.sv
// Control/status bundle for the loadable up/down counter.
// master drives the controls and reads the count; slave is the counter.
interface cntr_load_mode_if #(
    parameter int WIDTH  = 48,
    parameter int STEP_W = 18
);
    logic              ce;
    logic              load;
    logic [WIDTH-1:0]  c_in;
    logic              add_sub;
    logic [STEP_W-1:0] step;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  limit;
    logic              clr_ovf;
    logic [WIDTH-1:0]  cntr_out;
    logic              tc;
    logic              ovf;

    modport master (
        output ce, load, c_in, add_sub, step, mode, limit, clr_ovf,
        input  cntr_out, tc, ovf
    );

    modport slave (
        input  ce, load, c_in, add_sub, step, mode, limit, clr_ovf,
        output cntr_out, tc, ovf
    );
endinterface

// File: rtl/cntr_load_mode.sv
// Loadable up/down counter with programmable step and run-time count mode:
// free wrap, saturate to [0,LIMIT], or modulo LIMIT+1. Registered count,
// one-cycle terminal-count pulse and a sticky overflow flag. Latency 1.
module cntr_load_mode #(
    parameter int WIDTH  = 48,
    parameter int STEP_W = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    cntr_load_mode_if.slave    bus
);
    typedef enum logic [1:0] {
        MODE_WRAP  = 2'b00,
        MODE_SAT   = 2'b01,
        MODE_MOD   = 2'b10,
        MODE_WRAP2 = 2'b11
    } mode_e;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;

    // All arithmetic is one bit wider than the counter so carries, borrows
    // and LIMIT+1 are represented exactly.
    logic [WIDTH:0] cnt_x, s_x, l_x, l1_x;
    logic [WIDTH:0] sum_x, diff_x, mod_up_x, mod_dn_x;
    logic           borrow, over_lim, bounded;
    mode_e          mode;

    // Wide operands and candidate results for every mode.
    always_comb begin
        mode     = mode_e'(bus.mode);
        cnt_x    = {1'b0, cnt_q};
        s_x      = (WIDTH+1)'(bus.step);
        l_x      = {1'b0, bus.limit};
        l1_x     = l_x + 1'b1;
        sum_x    = cnt_x + s_x;
        diff_x   = cnt_x - s_x;
        borrow   = cnt_x < s_x;
        // cnt <= LIMIT and S <= LIMIT+1 keep both modulo results in range.
        mod_up_x = sum_x - l1_x;
        mod_dn_x = cnt_x + l1_x - s_x;
        over_lim = cnt_x > l_x;
        bounded  = (mode == MODE_SAT) || (mode == MODE_MOD);
    end

    // Next count, terminal-count pulse and overflow-set decision.
    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;
        if (bus.load) begin
            if (bounded && (bus.c_in > bus.limit)) begin
                cnt_d   = bus.limit;
                ovf_set = 1'b1;
            end else begin
                cnt_d = bus.c_in;
            end
        end else if (bus.ce) begin
            if (bounded && over_lim) begin
                // Count left out of range by a LIMIT/mode change: snap back.
                cnt_d   = bus.limit;
                tc_d    = 1'b1;
                ovf_set = 1'b1;
            end else begin
                case (mode)
                    MODE_SAT: begin
                        if (bus.add_sub) begin
                            if (sum_x > l_x) begin
                                cnt_d = bus.limit;
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = sum_x[WIDTH-1:0];
                            end
                        end else if (borrow) begin
                            cnt_d = '0;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = diff_x[WIDTH-1:0];
                        end
                    end
                    MODE_MOD: begin
                        if (s_x > l1_x) begin
                            // Step larger than the modulus: refuse to count.
                            ovf_set = 1'b1;
                        end else if (bus.add_sub) begin
                            if (sum_x > l_x) begin
                                cnt_d = mod_up_x[WIDTH-1:0];
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = sum_x[WIDTH-1:0];
                            end
                        end else if (borrow) begin
                            cnt_d = mod_dn_x[WIDTH-1:0];
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = diff_x[WIDTH-1:0];
                        end
                    end
                    default: begin
                        if (bus.add_sub) begin
                            cnt_d = sum_x[WIDTH-1:0];
                            tc_d  = sum_x[WIDTH];
                        end else begin
                            cnt_d = diff_x[WIDTH-1:0];
                            tc_d  = borrow;
                        end
                    end
                endcase
            end
        end
        if (tc_d) ovf_set = 1'b1;
        // Setting wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~bus.clr_ovf);
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.cntr_out = cnt_q;
    assign bus.tc       = tc_q;
    assign bus.ovf      = ovf_q;
endmodule
